fetch_ctrl: RTL and testbench

Front-end sequencer directly upstream of the instruction fetch unit (`IFetch`). It owns the program counter and issues one fetch address at a time over the fetch unit's address handshake. It collects the returned instruction and presents the (pc, instruction) pair to decode on a registered valid/ready interface. It also applies redirects from the back end, discarding any fetch response that is still in flight when a redirect arrives.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding,
// reset vector default, PC step and the decode-side output record.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_DROP = 2'd2,
    S_OUT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] PC_INCR              = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } fetch_out_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the IFetch address/data handshakes, the decode-side pair and
// the redirect request; master is the sequencer, slave its surroundings.
interface fetch_ctrl_if;
  logic [31:0] if_pc;
  logic        if_avalid;
  logic        if_aready;
  logic [31:0] if_inst;
  logic        if_dvalid;
  logic        if_dready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_exc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output if_pc, if_avalid, if_dready, out_valid, out_pc, out_inst, out_exc,
    input  if_aready, if_inst, if_dvalid, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  if_pc, if_avalid, if_dready, out_valid, out_pc, out_inst, out_exc,
    output if_aready, if_inst, if_dvalid, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, one outstanding IFetch request, hold register
// towards decode, redirects. FETCH_CTRL_MISALIGN_EN enables misaligned-target faults.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  fetch_out_t   out_q, out_d;
  logic         halt_q, halt_d;
  logic         exc_pend_q, exc_pend_d;
  logic         afire, dfire, ofire;
  logic [31:0]  target;
  logic         misaligned;

`ifdef FETCH_CTRL_MISALIGN_EN
  assign target     = bus.redirect_pc;
  assign misaligned = (bus.redirect_pc[1:0] != 2'b00);
  assign bus.out_exc = out_q.exc;
`else
  logic unused_bits;
  assign target      = {bus.redirect_pc[31:2], 2'b00};
  assign misaligned  = 1'b0;
  assign bus.out_exc = 1'b0;
  assign unused_bits = ^{bus.redirect_pc[1:0], out_q.exc};
`endif

  assign afire = bus.if_avalid && bus.if_aready;
  assign dfire = bus.if_dready && bus.if_dvalid;
  assign ofire = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_RESP;
    else       state_q <= state_d;
  end

  // Misaligned redirects land in S_OUT (directly, or via S_DROP when an old
  // response still has to be drained, tracked by exc_pend_q).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (bus.redirect_valid)
          state_d = afire ? S_DROP : (misaligned ? S_OUT : S_REQ);
        else if (afire)
          state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.redirect_valid)
          state_d = !dfire ? S_DROP : (misaligned ? S_OUT : S_REQ);
        else if (dfire)
          state_d = S_OUT;
      end
      S_DROP: begin
        if (dfire)
          state_d = (bus.redirect_valid ? misaligned : exc_pend_q) ? S_OUT : S_REQ;
      end
      S_OUT: begin
        if (bus.redirect_valid)
          state_d = misaligned ? S_OUT : S_REQ;
        else if (ofire)
          state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    bus.if_pc     = pc_q;
    bus.if_avalid = (state_q == S_REQ) && !halt_q;
    bus.if_dready = (state_q == S_RESP) || (state_q == S_DROP);
    bus.out_valid = (state_q == S_OUT);
    bus.out_pc    = out_q.pc;
    bus.out_inst  = out_q.inst;
  end

  always_comb begin
    pc_d       = pc_q;
    out_d      = out_q;
    halt_d     = halt_q;
    exc_pend_d = exc_pend_q;
    if (bus.redirect_valid) begin
      pc_d       = target;
      halt_d     = misaligned;
      exc_pend_d = misaligned && (state_d == S_DROP);
      if (misaligned)
        out_d = '{pc: target, inst: '0, exc: 1'b1};
    end else begin
      if ((state_q == S_RESP) && dfire) begin
        pc_d  = pc_q + PC_INCR;
        out_d = '{pc: pc_q, inst: bus.if_inst, exc: 1'b0};
      end
      if ((state_q == S_DROP) && dfire)
        exc_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      out_q      <= '0;
      halt_q     <= 1'b0;
      exc_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      halt_q     <= halt_d;
      exc_pend_q <= exc_pend_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: IFetch model plus an epoch-tagged
// request queue reference; honours FETCH_CTRL_MISALIGN_EN when defined.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fetch_ctrl_if bus();
  fetch_ctrl #(.RESET_VECTOR(RV)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] epoch;
  } req_t;

  // IFetch model state
  bit          fm_pend;
  int          fm_cnt;
  logic [31:0] fm_addr;
  int          lat_lo, lat_hi;

  // Reference model state
  req_t        q[$];
  logic [31:0] epoch;
  logic [31:0] exp_pc;
  bit          exp_present;
  logic [31:0] exp_present_pc;
  bit          prev_hold;
  logic [31:0] prev_pc, prev_inst;
  bit          exc_wait;
  logic [31:0] exc_pc;
  bit          halted;
  int          consumed;
  bit          tick_afire;
  logic [31:0] last_afire_pc;
  int          last_afire_cyc, afire_gap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0013;
    if (a == 32'h8000_0004) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] p);
`ifdef FETCH_CTRL_MISALIGN_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit rdy, input bit ard, input bit rv, input logic [31:0] rpc);
    bit          afire, dfire, ofire, next_present;
    logic [31:0] afire_pc, next_pc;
    req_t        r;
    @(negedge clock);
    bus.out_ready      = rdy;
    bus.if_aready      = ard;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    afire      = bus.if_avalid && ard;
    dfire      = bus.if_dready && bus.if_dvalid;
    ofire      = bus.out_valid && rdy;
    afire_pc   = bus.if_pc;
    tick_afire = afire;
    next_present = 1'b0;
    next_pc      = '0;
    if (!reset) begin
      if (exp_present) begin
        check("present_valid", bus.out_valid, 1);
        check("present_pc", bus.out_pc, exp_present_pc);
        check("present_inst", bus.out_inst, mem_word(exp_present_pc));
      end else if (prev_hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_pc", bus.out_pc, prev_pc);
        check("hold_inst", bus.out_inst, prev_inst);
      end else if (!exc_wait) begin
        check("idle_valid", bus.out_valid, 0);
      end
      if (bus.out_valid) begin
        check("avalid_while_out", bus.if_avalid, 0);
        check("dready_while_out", bus.if_dready, 0);
      end
      if (halted) check("halt_no_avalid", bus.if_avalid, 0);
      if (afire) begin
        check("one_outstanding", 32'(q.size()), 0);
        check("fetch_pc", afire_pc, exp_pc);
        afire_gap      = cyc - last_afire_cyc;
        last_afire_cyc = cyc;
        last_afire_pc  = afire_pc;
      end
      if (dfire) begin
        check("dfire_has_req", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          r = q.pop_front();
          if (r.epoch == epoch && !rv) begin
            next_present = 1'b1;
            next_pc      = r.addr;
          end
        end
      end
      if (afire) q.push_back('{addr: afire_pc, epoch: epoch});
      if (ofire) begin
        if (exc_wait) begin
          check("exc_flag", bus.out_exc, 1);
          check("exc_pc", bus.out_pc, exc_pc);
          exc_wait = 1'b0;
        end else begin
          check("consume_pc", bus.out_pc, exp_pc);
          check("consume_inst", bus.out_inst, mem_word(exp_pc));
          check("consume_exc", bus.out_exc, 0);
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
      end
      if (rv) begin
        epoch  = epoch + 32'd1;
        exp_pc = tgt_of(rpc);
`ifdef FETCH_CTRL_MISALIGN_EN
        exc_wait = (rpc[1:0] != 2'b00);
        exc_pc   = rpc;
        halted   = exc_wait;
`endif
      end
      prev_hold      = bus.out_valid && !rdy && !rv;
      prev_pc        = bus.out_pc;
      prev_inst      = bus.out_inst;
      exp_present    = next_present;
      exp_present_pc = next_pc;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (!reset) begin
      if (afire) begin
        fm_pend       = 1'b1;
        fm_addr       = afire_pc;
        fm_cnt        = int'($urandom_range(lat_hi, lat_lo)) - 1;
        bus.if_dvalid = 1'b0;
      end else if (fm_pend) begin
        if (fm_cnt <= 1) begin
          bus.if_dvalid = 1'b1;
          bus.if_inst   = mem_word(fm_addr);
          fm_pend       = 1'b0;
        end else begin
          fm_cnt--;
        end
      end
    end
  endtask

  task automatic wait_afire(input string tag, input int max);
    int n = 0;
    tick_afire = 1'b0;
    while (!tick_afire && n < max) begin
      tick(1, 1, 0, 32'h0);
      n++;
    end
    check(tag, 32'(tick_afire), 1);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (!bus.out_valid && n < max) begin
      tick(0, 1, 0, 32'h0);
      n++;
    end
    check(tag, bus.out_valid, 1);
  endtask

  initial begin
    int          c0;
    logic [31:0] pc0, inst0;
    bus.out_ready      = 1'b0;
    bus.if_aready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_dvalid      = 1'b0;
    bus.if_inst        = '0;
    lat_lo = 2; lat_hi = 2;
    epoch = '0; exp_pc = RV; exp_present = 1'b0; prev_hold = 1'b0;
    exc_wait = 1'b0; exc_pc = '0; halted = 1'b0; consumed = 0;
    last_afire_pc = '0; last_afire_cyc = 0; afire_gap = 0;
    // IFetch returns the reset-vector word unrequested
    q.push_back('{addr: RV, epoch: 32'h0});
    fm_pend = 1'b1; fm_addr = RV; fm_cnt = 2;

    repeat (3) tick(0, 0, 0, 32'h0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_out_exc", bus.out_exc, 0);
    check("rst_if_avalid", bus.if_avalid, 0);
    check("rst_if_dready", bus.if_dready, 1);
    check("rst_if_pc", bus.if_pc, RV);
    reset = 1'b0;

    // Two instructions from the reset vector, then the fetch of +8
    wait_afire("afire_4_timeout", 30);
    check("afire_4_pc", last_afire_pc, 32'h8000_0004);
    wait_afire("afire_8_timeout", 30);
    check("afire_8_pc", last_afire_pc, 32'h8000_0008);
    check("turnaround", 32'(afire_gap), 32'd4);
    check("consumed_two", 32'(consumed), 32'd2);

    // Redirect while 0x80000008 is in flight
    tick(1, 1, 1, 32'h8000_0100);
    wait_afire("redir100_timeout", 30);
    check("redir100_pc", last_afire_pc, 32'h8000_0100);
    check("stale_not_consumed", 32'(consumed), 32'd2);

    // Decode stall for 10 cycles
    wait_valid("stall_valid_timeout", 30);
    pc0 = bus.out_pc; inst0 = bus.out_inst;
    repeat (10) tick(0, 1, 0, 32'h0);
    check("stall_pc", bus.out_pc, pc0);
    check("stall_inst", bus.out_inst, inst0);

    // Redirect coincident with an address fire
    for (int i = 0; i < 30 && !bus.if_avalid; i++) tick(1, 1, 0, 32'h0);
    check("req_avalid", bus.if_avalid, 1);
    tick(1, 1, 1, 32'h8000_0200);
    check("drop_state", 32'(dut.state_q), 32'(S_DROP));
    wait_afire("redir200_timeout", 30);
    check("redir200_pc", last_afire_pc, 32'h8000_0200);

    // Redirect coincident with out_fire
    wait_valid("out_valid_timeout", 30);
    c0 = consumed;
    tick(1, 1, 1, 32'h8000_0300);
    check("consumed_once", 32'(consumed), 32'(c0 + 1));
    wait_afire("redir300_timeout", 30);
    check("redir300_pc", last_afire_pc, 32'h8000_0300);

    // Misaligned redirect target
    tick(1, 1, 1, 32'h8000_0102);
`ifdef FETCH_CTRL_MISALIGN_EN
    wait_valid("exc_valid_timeout", 30);
    check("mis_exc", bus.out_exc, 1);
    check("mis_pc", bus.out_pc, 32'h8000_0102);
    tick(1, 1, 0, 32'h0);
    repeat (8) begin
      tick(1, 1, 0, 32'h0);
      check("mis_stall", bus.if_avalid, 0);
    end
    tick(1, 1, 1, 32'h8000_0000);
    wait_afire("realign_timeout", 30);
    check("realign_pc", last_afire_pc, 32'h8000_0000);
`else
    wait_afire("mis_timeout", 30);
    check("mis_forced_pc", last_afire_pc, 32'h8000_0100);
`endif

    // Randomised traffic against the reference model
    lat_lo = 2; lat_hi = 5;
    c0 = consumed;
    for (int i = 0; i < 2000; i++) begin
      bit          rdy, ard, rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(9, 0) < 7);
      ard = ($urandom_range(9, 0) < 6);
      rv  = ($urandom_range(24, 0) == 0);
      rpc = 32'h8000_0000 + (32'($urandom_range(255, 0)) << 2);
`ifndef FETCH_CTRL_MISALIGN_EN
      rpc = rpc | 32'($urandom_range(3, 0));
`endif
      tick(rdy, ard, rv, rpc);
    end
    check("random_progress", 32'(consumed - c0 >= 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
